// File: rtl/alu_pkg.sv
// Opcodes, request-FSM states and legal opcode range shared by the ALU and its request master.
// ALU_REQ_DIVZERO_CHECK_EN: when defined, divide-by-zero requests are rejected without reaching the ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MULT = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_CMP  = 4'b0111;

    // Legal opcodes are the contiguous range OP_ADD..OP_LAST_LEGAL.
    localparam logic [3:0] OP_LAST_LEGAL = OP_CMP;

`ifdef ALU_REQ_DIVZERO_CHECK_EN
    localparam bit DIVZERO_CHECK = 1'b1;
`else
    localparam bit DIVZERO_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/alu_req_master_if.sv
// Command, ALU-drive and response bundle between alu_req_master and its environment.
// master: the request master's view; slave: the command source, ALU and response consumer.
interface alu_req_master_if #(
    parameter int Width = 4
);

    logic               cmd_valid;
    logic               cmd_ready;
    logic [Width-1:0]   cmd_a;
    logic [Width-1:0]   cmd_b;
    logic [Width-1:0]   cmd_op;

    logic [Width-1:0]   alu_a;
    logic [Width-1:0]   alu_b;
    logic [Width-1:0]   alu_op;
    logic               alu_enable;
    logic [2*Width-1:0] alu_result;

    logic               rsp_valid;
    logic               rsp_ready;
    logic [2*Width-1:0] rsp_data;
    logic               rsp_err;
    logic [7:0]         done_count;

    modport master (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_op, alu_enable,
               rsp_valid, rsp_data, rsp_err, done_count
    );

    modport slave (
        output cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_op, alu_enable,
               rsp_valid, rsp_data, rsp_err, done_count
    );

endinterface

// File: rtl/alu_op_check.sv
// Opcode legality and divide-by-zero screen for an incoming command; purely combinational.
// Latency: 0 cycles. Backpressure: none, evaluated every cycle. ALU_REQ_DIVZERO_CHECK_EN adds div/0 rejection.
module alu_op_check
    import alu_pkg::*;
#(
    parameter int Width = 4
) (
    input  logic [Width-1:0] i_op,
    input  logic [Width-1:0] i_b,
    output logic             o_reject
);

    logic w_legal;
    logic w_div_zero;

    assign w_legal    = (i_op <= Width'(OP_LAST_LEGAL));
    assign w_div_zero = (i_op == Width'(OP_DIV)) && (i_b == '0);

    // A rejected command never reaches the ALU and is answered with an error response.
    assign o_reject = ~w_legal | (DIVZERO_CHECK & w_div_zero);

endmodule

// File: rtl/alu_req_master.sv
// Issues one command at a time to a registered ALU and returns its result as a held response.
// Latency: 3 cycles accept->rsp_valid (1 for rejected ops). Backpressure: response held until rsp_ready; no accept meanwhile.
module alu_req_master
    import alu_pkg::*;
#(
    parameter int Width = 4
) (
    input  logic             clk,
    input  logic             arst,
    alu_req_master_if.master bus
);

    state_t             r_state;
    state_t             w_next;
    logic [Width-1:0]   r_alu_a;
    logic [Width-1:0]   r_alu_b;
    logic [Width-1:0]   r_alu_op;
    logic [2*Width-1:0] r_rsp_data;
    logic               r_rsp_err;
    logic [7:0]         r_done_count;

    logic               w_reject;
    logic               w_accept;
    logic               w_rsp_hs;
    logic               w_cmd_ready;
    logic               w_alu_enable;
    logic               w_rsp_valid;

    alu_op_check #(
        .Width (Width)
    ) u_op_check (
        .i_op     (bus.cmd_op),
        .i_b      (bus.cmd_b),
        .o_reject (w_reject)
    );

    assign w_accept = (r_state == ST_IDLE) && bus.cmd_valid;
    assign w_rsp_hs = (r_state == ST_RESP) && bus.rsp_ready;

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_cmd_ready  = 1'b0;
        w_alu_enable = 1'b0;
        w_rsp_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    w_next = w_reject ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_alu_enable = 1'b1;
                w_next       = ST_WAIT;
            end
            ST_WAIT: begin
                w_next = ST_RESP;
            end
            ST_RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
            r_done_count <= 8'd0;
        end else begin
            if (w_accept) begin
                r_alu_a  <= bus.cmd_a;
                r_alu_b  <= bus.cmd_b;
                r_alu_op <= bus.cmd_op;
                if (w_reject) begin
                    r_rsp_data <= '0;
                    r_rsp_err  <= 1'b1;
                end
            end
            // The ALU registers its result on the ISSUE edge, so it is valid throughout WAIT.
            if (r_state == ST_WAIT) begin
                r_rsp_data <= bus.alu_result;
                r_rsp_err  <= 1'b0;
            end
            if (w_rsp_hs) begin
                r_done_count <= r_done_count + 8'd1;
            end
        end
    end

    assign bus.cmd_ready  = w_cmd_ready;
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.alu_op     = r_alu_op;
    assign bus.alu_enable = w_alu_enable;
    assign bus.rsp_valid  = w_rsp_valid;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.rsp_err    = r_rsp_err;
    assign bus.done_count = r_done_count;

endmodule

// File: tb/tb_alu_req_master.sv
// Directed bench for alu_req_master with a behavioural registered ALU on the slave side.
module tb_alu_req_master;
    import alu_pkg::*;

    localparam int W = 4;

    logic clk = 1'b0;
    logic arst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    alu_req_master_if #(.Width(W)) bus ();

    alu_req_master #(.Width(W)) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        logic [7:0] ea;
        logic [7:0] eb;
        ea = {4'b0, a};
        eb = {4'b0, b};
        case (op)
            OP_ADD:  return ea + eb;
            OP_SUB:  return ea - eb;
            OP_MULT: return ea * eb;
            OP_DIV:  return (b == 4'd0) ? 8'hFF : ea / eb;
            OP_AND:  return ea & eb;
            OP_OR:   return ea | eb;
            OP_XOR:  return ea ^ eb;
            OP_CMP:  return {6'b0, (a > b), (a == b)};
            default: return 8'h00;
        endcase
    endfunction

    // Registered ALU: result appears the cycle after alu_enable.
    always @(posedge clk) begin
        if (bus.alu_enable) begin
            bus.alu_result <= alu_f(bus.alu_a, bus.alu_b, bus.alu_op);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        int n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("cmd_ready_before_send", 16'(bus.cmd_ready), 16'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_op    = op;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        arst          = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_op    = '0;
        bus.rsp_ready = 1'b1;
        bus.alu_result = '0;
        #3;
        chk("rst_alu_a",      16'(bus.alu_a),      16'd0);
        chk("rst_alu_op",     16'(bus.alu_op),     16'd0);
        chk("rst_alu_enable", 16'(bus.alu_enable), 16'd0);
        chk("rst_rsp_valid",  16'(bus.rsp_valid),  16'd0);
        chk("rst_rsp_data",   16'(bus.rsp_data),   16'd0);
        chk("rst_done_count", 16'(bus.done_count), 16'd0);
        chk("rst_cmd_ready",  16'(bus.cmd_ready),  16'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        arst = 1'b1;
        tick();

        // Add 3+5 with consumer always ready
        send(4'd3, 4'd5, OP_ADD);
        chk("add_c1_enable", 16'(bus.alu_enable), 16'd1);
        chk("add_c1_alu_a",  16'(bus.alu_a),      16'd3);
        chk("add_c1_valid",  16'(bus.rsp_valid),  16'd0);
        tick();
        chk("add_c2_enable", 16'(bus.alu_enable), 16'd0);
        chk("add_c2_valid",  16'(bus.rsp_valid),  16'd0);
        tick();
        chk("add_c3_valid",  16'(bus.rsp_valid),  16'd1);
        chk("add_c3_data",   16'(bus.rsp_data),   16'd8);
        chk("add_c3_err",    16'(bus.rsp_err),    16'd0);
        chk("add_c3_ready",  16'(bus.cmd_ready),  16'd0);
        tick();
        chk("add_done",      16'(bus.done_count), 16'd1);
        chk("add_idle_valid",16'(bus.rsp_valid),  16'd0);
        chk("add_idle_ready",16'(bus.cmd_ready),  16'd1);

        // Mult 7*9
        send(4'd7, 4'd9, OP_MULT);
        tick();
        tick();
        chk("mul_valid", 16'(bus.rsp_valid),  16'd1);
        chk("mul_data",  16'(bus.rsp_data),   16'd63);
        chk("mul_err",   16'(bus.rsp_err),    16'd0);
        tick();
        chk("mul_done",  16'(bus.done_count), 16'd2);

        // Divide 12/3 under 5 cycles of backpressure, with a competing command offered
        bus.rsp_ready = 1'b0;
        send(4'd12, 4'd3, OP_DIV);
        tick();
        tick();
        chk("bp_valid_rise", 16'(bus.rsp_valid), 16'd1);
        chk("bp_data_rise",  16'(bus.rsp_data),  16'd4);
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = 4'd1;
        bus.cmd_b     = 4'd2;
        bus.cmd_op    = OP_ADD;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_valid", 16'(bus.rsp_valid),  16'd1);
            chk("bp_hold_data",  16'(bus.rsp_data),   16'd4);
            chk("bp_cmd_ready",  16'(bus.cmd_ready),  16'd0);
            chk("bp_alu_a",      16'(bus.alu_a),      16'd12);
            chk("bp_done",       16'(bus.done_count), 16'd2);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        chk("bp_release_valid", 16'(bus.rsp_valid),  16'd0);
        chk("bp_release_done",  16'(bus.done_count), 16'd3);
        tick();
        chk("bp_single_hs",     16'(bus.done_count), 16'd3);

        // Illegal opcode 1010
        send(4'd2, 4'd2, 4'b1010);
        chk("ill_valid",  16'(bus.rsp_valid),  16'd1);
        chk("ill_err",    16'(bus.rsp_err),    16'd1);
        chk("ill_data",   16'(bus.rsp_data),   16'd0);
        chk("ill_enable", 16'(bus.alu_enable), 16'd0);
        tick();
        chk("ill_done",   16'(bus.done_count), 16'd4);

        // Divide by zero
        send(4'd9, 4'd0, OP_DIV);
`ifdef ALU_REQ_DIVZERO_CHECK_EN
        chk("dz_enable", 16'(bus.alu_enable), 16'd0);
        chk("dz_valid",  16'(bus.rsp_valid),  16'd1);
        chk("dz_err",    16'(bus.rsp_err),    16'd1);
        chk("dz_data",   16'(bus.rsp_data),   16'd0);
`else
        chk("dz_enable", 16'(bus.alu_enable), 16'd1);
        tick();
        tick();
        chk("dz_valid",  16'(bus.rsp_valid),  16'd1);
        chk("dz_err",    16'(bus.rsp_err),    16'd0);
        chk("dz_data",   16'(bus.rsp_data),   16'd255);
`endif
        tick();
        chk("dz_done",   16'(bus.done_count), 16'd5);

        // Reset asserted during WAIT
        send(4'd5, 4'd6, OP_ADD);
        tick();
        #2;
        arst = 1'b0;
        #1;
        chk("mid_rst_alu_a",  16'(bus.alu_a),      16'd0);
        chk("mid_rst_alu_b",  16'(bus.alu_b),      16'd0);
        chk("mid_rst_enable", 16'(bus.alu_enable), 16'd0);
        chk("mid_rst_valid",  16'(bus.rsp_valid),  16'd0);
        chk("mid_rst_data",   16'(bus.rsp_data),   16'd0);
        chk("mid_rst_err",    16'(bus.rsp_err),    16'd0);
        chk("mid_rst_done",   16'(bus.done_count), 16'd0);
        @(negedge clk);
        arst = 1'b1;
        tick();
        chk("post_rst_ready", 16'(bus.cmd_ready), 16'd1);
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_no_rsp", 16'(bus.rsp_valid), 16'd0);
            tick();
        end
        send(4'd1, 4'd1, OP_ADD);
        tick();
        tick();
        chk("post_rst_valid", 16'(bus.rsp_valid),  16'd1);
        chk("post_rst_data",  16'(bus.rsp_data),   16'd2);
        tick();
        chk("post_rst_done",  16'(bus.done_count), 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
